fifo_lvl: RTL

Parametrised synchronous show-ahead FIFO that extends the basic system FIFO. It adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags with a clear input. It sits between producers and consumers in the system datapath (e.g. UART and bus bridges), where flow control needs early warning and lost data must be detectable. All `2**W` entries are usable.

---
 rtl/fifo_lvl_if.sv | 23 ++
 rtl/fifo_lvl.sv | 67 ++++++
 2 files changed

// File: rtl/fifo_lvl_if.sv
// fifo_lvl_if: write/read handshake, data and status bundle of the level-reporting FIFO
interface fifo_lvl_if #(parameter int B = 8, parameter int W = 4);
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
  modport master (
    output wr, w_data, rd, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  wr, w_data, rd, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_lvl.sv
// fifo_lvl: show-ahead FIFO with occupancy count, almost-full/empty and sticky error flags
module fifo_lvl #(
  parameter int B  = 8,
  parameter int W  = 4,
  parameter int AF = 12,
  parameter int AE = 2
) (
  input logic       clk,
  input logic       reset,
  fifo_lvl_if.slave f
);
  localparam int D = 2 ** W;
  logic [B-1:0] mem_q [D];
  logic [W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d, full_q, full_d;
  logic         ae_q, ae_d, af_q, af_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         wa, ra;
  // A write into a full FIFO is still accepted when a pop frees the head slot the same cycle
  always_comb begin
    wa      = f.wr & (~full_q | f.rd);
    ra      = f.rd & ~empty_q;
    wp_d    = wp_q + W'(wa);
    rp_d    = rp_q + W'(ra);
    count_d = count_q + (W+1)'(wa) - (W+1)'(ra);
    empty_d = count_d == '0;
    full_d  = count_d == (W+1)'(D);
    ae_d    = count_d <= (W+1)'(AE);
    af_d    = count_d >= (W+1)'(AF);
    ovf_d   = (f.wr & ~wa) | (ovf_q & ~f.clr_err);
    unf_d   = (f.rd & empty_q) | (unf_q & ~f.clr_err);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk)
    if (wa && !reset) mem_q[wp_q] <= f.w_data;
  assign f.r_data       = mem_q[rp_q];
  assign f.empty        = empty_q;
  assign f.full         = full_q;
  assign f.almost_empty = ae_q;
  assign f.almost_full  = af_q;
  assign f.count        = count_q;
  assign f.overflow     = ovf_q;
  assign f.underflow    = unf_q;
endmodule
